// File: rtl/mult_seq_if.sv
// -----------------------------------------------------------------------------
// mult_seq_if
//   Bundles the signals of the sequential multiplier: the multiply request and
//   response, the datapath's ALU request, and the connection to the shared ALU.
//
//   Signals
//     start, opA, opB        multiply request (requester -> sequencer)
//     busy, done             sequencer status; done is a one-cycle pulse
//     result, ovf            low word of the product and its overflow flag
//     dp_op, dp_a, dp_b      datapath ALU request (requester -> sequencer)
//     dp_stall               datapath must hold its request while high
//     alu_op, alu_a, alu_b   drive the shared ALU (sequencer -> ALU)
//     alu_out                shared ALU result (ALU -> sequencer)
//
//   Modports
//     slave   the multiplier sequencer
//     master  the surrounding environment (requester, datapath and ALU)
// -----------------------------------------------------------------------------
interface mult_seq_if #(
   parameter int unsigned WORD_W = 32
);
   logic              start;
   logic [WORD_W-1:0] opA;
   logic [WORD_W-1:0] opB;
   logic              busy;
   logic              done;
   logic [WORD_W-1:0] result;
   logic              ovf;

   logic [3:0]        dp_op;
   logic [WORD_W-1:0] dp_a;
   logic [WORD_W-1:0] dp_b;
   logic              dp_stall;

   logic [3:0]        alu_op;
   logic [WORD_W-1:0] alu_a;
   logic [WORD_W-1:0] alu_b;
   logic [WORD_W-1:0] alu_out;

   modport slave (
      input  start, opA, opB, dp_op, dp_a, dp_b, alu_out,
      output busy, done, result, ovf, dp_stall, alu_op, alu_a, alu_b
   );

   modport master (
      output start, opA, opB, dp_op, dp_a, dp_b, alu_out,
      input  busy, done, result, ovf, dp_stall, alu_op, alu_a, alu_b
   );
endinterface

// File: rtl/mult_seq.sv
// -----------------------------------------------------------------------------
// mult_seq
//   Unsigned shift-and-add multiplier that borrows a shared ALU. While idle the
//   ALU is passed straight through to the datapath; once a multiply is accepted
//   the sequencer owns the ALU until it returns to idle, and dp_stall tells the
//   datapath to hold its request.
//
//   Registers: M (multiplicand, shifted left), Q (multiplier, shifted right),
//   P (partial product). Each set bit of Q costs an ADD cycle, every bit up to
//   the highest set bit costs an EVAL and a SHIFT cycle.
//
//   Ports
//     CLK    clock, rising edge
//     nRST   asynchronous active-low reset
//     bus    mult_seq_if.slave: multiply request/response, datapath ALU
//            request and shared ALU connection
//
//   Only WORD_W = 32 is supported (shift amount and ALU opcodes assume it).
// -----------------------------------------------------------------------------
module mult_seq #(
   parameter int unsigned WORD_W = 32
) (
   input logic        CLK,
   input logic        nRST,
   mult_seq_if.slave  bus
);

   localparam logic [3:0] AluSll = 4'b0000;
   localparam logic [3:0] AluAdd = 4'b0010;

   typedef enum logic [2:0] {
      StIdle,
      StEval,
      StAdd,
      StShift,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [WORD_W-1:0] m_q, m_d;
   logic [WORD_W-1:0] q_q, q_d;
   logic [WORD_W-1:0] p_q, p_d;
   logic [WORD_W-1:0] result_q, result_d;
   logic              ovf_q, ovf_d;
   logic [WORD_W-1:0] q_shr;

   assign q_shr = q_q >> 1;

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q  <= StIdle;
         m_q      <= '0;
         q_q      <= '0;
         p_q      <= '0;
         result_q <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         m_q      <= m_d;
         q_q      <= q_d;
         p_q      <= p_d;
         result_q <= result_d;
         ovf_q    <= ovf_d;
      end
   end

   // ---------------------------------------------------------------------------
   // ALU ownership. Kept apart from the next-state logic so the path
   // alu_a -> ALU -> alu_out never closes a loop through one process.
   // ---------------------------------------------------------------------------
   always_comb begin
      bus.alu_op = AluAdd;
      bus.alu_a  = '0;
      bus.alu_b  = '0;
      unique case (state_q)
         StIdle: begin
            bus.alu_op = bus.dp_op;
            bus.alu_a  = bus.dp_a;
            bus.alu_b  = bus.dp_b;
         end
         StAdd: begin
            bus.alu_op = AluAdd;
            bus.alu_a  = p_q;
            bus.alu_b  = m_q;
         end
         StShift: begin
            bus.alu_op = AluSll;
            bus.alu_a  = m_q;
            bus.alu_b  = {{(WORD_W-1){1'b0}}, 1'b1};
         end
         default: begin
            // EVAL and DONE: ALU held at a harmless ADD 0,0
            bus.alu_op = AluAdd;
            bus.alu_a  = '0;
            bus.alu_b  = '0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      m_d      = m_q;
      q_d      = q_q;
      p_d      = p_q;
      result_d = result_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               m_d     = bus.opA;
               q_d     = bus.opB;
               p_d     = '0;
               ovf_d   = 1'b0;
               state_d = StEval;
            end
         end
         StEval: begin
            if (q_q == '0) begin
               // Load result on entry to DONE so it is valid alongside done
               result_d = p_q;
               state_d  = StDone;
            end else if (q_q[0]) begin
               state_d = StAdd;
            end else begin
               state_d = StShift;
            end
         end
         StAdd: begin
            p_d = bus.alu_out;
            // Unsigned wrap of the partial sum means a carry out of bit 31
            ovf_d   = ovf_q | (bus.alu_out < p_q);
            state_d = StShift;
         end
         StShift: begin
            m_d = bus.alu_out;
            q_d = q_shr;
            // Losing M[31] only matters if a later multiplier bit would add it
            ovf_d   = ovf_q | (m_q[WORD_W-1] & (q_shr != '0));
            state_d = StEval;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign bus.busy     = (state_q != StIdle);
   assign bus.dp_stall = (state_q != StIdle);
   assign bus.done     = (state_q == StDone);
   assign bus.result   = result_q;
   assign bus.ovf      = ovf_q;

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 SHALL have parameter: WORD_W, 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port: CLK  in  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port: nRST  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: start  in  1  request an unsigned multiply; sampled only in IDLE.
REQ-005 SHALL have port: opA  in  32  multiplicand, captured with start.
REQ-006 SHALL have port: opB  in  32  multiplier, captured with start.
REQ-007 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-008 SHALL have port: done  out  1  one-cycle pulse, result valid.
REQ-009 SHALL have port: result  out  32  low 32 bits of opA*opB, held until next accepted start.
REQ-010 SHALL have port: ovf  out  1  true product exceeds 32 bits, held with result.
REQ-011 SHALL have port: dp_op  in  4  datapath ALU op request.
REQ-012 SHALL have port: dp_a, dp_b  in  32 each  datapath ALU operands.
REQ-013 SHALL have port: dp_stall  out  1  equals busy; datapath must hold its request.
REQ-014 SHALL have port: alu_op  out  4  drives shared ALU aluOp (SLL=0000, ADD=0010).
REQ-015 SHALL have port: alu_a, alu_b  out  32 each  drive ALU portA/portB.
REQ-016 SHALL have port: alu_out  in  32  ALU outPort; ALU flags unused.

Function
REQ-017 SHALL implement FSM states IDLE, EVAL, ADD, SHIFT, DONE with registers M, Q, P (32 bits each).
REQ-018 In IDLE, alu_op/alu_a/alu_b SHALL equal dp_op/dp_a/dp_b combinationally; in all other states the sequencer owns the ALU.
REQ-019 IDLE with start=1: M<=opA, Q<=opB, P<=0, ovf<=0, next EVAL; start=0: stay IDLE.
REQ-020 EVAL: Q==0 -> DONE; else Q[0]=1 -> ADD; else -> SHIFT; ALU driven ADD,0,0 (don't-care result).
REQ-021 ADD: drive ADD, alu_a=P, alu_b=M; P<=alu_out; ovf<=ovf | (alu_out < P, unsigned); next SHIFT.
REQ-022 SHIFT: drive SLL, alu_a=M, alu_b=1; M<=alu_out; Q<=Q>>1 (local, zero-fill); ovf<=ovf | (M[31] & (Q>>1)!=0); next EVAL.
REQ-023 DONE: done=1, result<=P registered on entry so valid in the DONE cycle; next IDLE.
REQ-024 Latency: with h = index of highest set bit of opB and w = popcount(opB), done SHALL assert 2+2*(h+1)+w cycles after the start cycle; opB=0 gives 2; maximum 98.
REQ-025 start while busy (including DONE) SHALL be ignored, with no effect on registers.
REQ-026 A start in the IDLE cycle directly after DONE SHALL be accepted normally; back-to-back operations SHALL be supported.
REQ-027 Arithmetic SHALL be modulo 2^32 and unsigned; ovf SHALL be exact, meaning set iff opA*opB >= 2^32.

Reset
REQ-028 nRST low SHALL immediately force state=IDLE, M=Q=P=0, result=0, ovf=0, done=0, busy=0, dp_stall=0, independent of CLK.
REQ-029 Reset asserted mid-operation SHALL abandon it with no done pulse; the first start after release SHALL be accepted normally.

Verification
REQ-030 Bench SHALL cover opA=3, opB=5 -> done exactly 10 cycles after start, result=0x0000000F, ovf=0.
REQ-031 Bench SHALL cover opA=0x12345678, opB=0 -> done at cycle 2, result=0, ovf=0; then opA=0, opB=0xFFFFFFFF -> done at cycle 98, result=0, ovf=0.
REQ-032 Bench SHALL cover opA=0xFFFFFFFF, opB=0xFFFFFFFF -> done at cycle 98, result=0x00000001, ovf=1; and opA=0x00010000, opB=0x00010000 -> result=0, ovf=1.
REQ-033 Bench SHALL cover start pulsed with opA=7, opB=9 at cycles 1 and 3 of an operation -> a single done, result=opA0*opB0 of the original start, registers unaffected.
REQ-034 Bench SHALL cover IDLE with dp_op=0011 (SUB), dp_a=10, dp_b=4 -> alu_op=0011, alu_a=10, alu_b=4, dp_stall=0 in the same cycle; while busy, dp_* changes do not reach the ALU.
REQ-035 Bench SHALL cover nRST asserted mid-operation between edges -> outputs zero immediately, no done; a new start with 6*7 -> result=42.
